exe_stage_mc: RTL

Multi-cycle, parametrised execute stage for the ARM pipeline. Sits between the ID/EX register and the memory stage and owns its own EX/MEM output register. Single-cycle data-processing, load/store address and branch-target work keeps the existing ALU path. MUL/MLA run on an iterative multiplier that stalls upstream through a ready handshake.

---
 rtl/exe_stage_mc_pkg.sv | 19 +
 rtl/exe_stage_mc_mul_iter.sv | 47 ++++
 rtl/exe_stage_mc.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/exe_stage_mc_pkg.sv
// exe_stage_mc_pkg: shared widths, ALU opcodes and FSM encoding for the execute stage.
package exe_stage_mc_pkg;
    localparam int WORD_WIDTH            = 32;
    localparam int REG_FILE_DEPTH        = 4;
    localparam int SIGNED_IMM_WIDTH      = 24;
    localparam int SHIFTER_OPERAND_WIDTH = 12;

    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    typedef enum logic {IDLE = 1'b0, MUL_BUSY = 1'b1} state_t;
endpackage

// File: rtl/exe_stage_mc_mul_iter.sv
// mul_iter: iterative shift-add multiplier retiring BITS multiplier bits per step.
module mul_iter #(
    parameter int WIDTH = 32,
    parameter int BITS  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic             abort,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    input  logic [WIDTH-1:0] addend,
    output logic [WIDTH-1:0] result,
    output logic             done
);
    localparam int L  = WIDTH / BITS;
    localparam int CW = L > 1 ? $clog2(L) : 1;

    logic [WIDTH-1:0] mcand, mplier, acc;
    logic [CW-1:0]    count;

    // result is the accumulator after the current step; on the last step it is the product
    assign result = acc + mcand * WIDTH'(mplier[BITS-1:0]);
    assign done   = count == CW'(L - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (abort) begin
            count <= '0;
        end else if (start) begin
            mcand  <= multiplicand;
            mplier <= multiplier;
            acc    <= addend;
            count  <= '0;
        end else if (step) begin
            acc    <= result;
            mcand  <= mcand << BITS;
            mplier <= mplier >> BITS;
            count  <= done ? '0 : count + CW'(1);
        end
    end
endmodule

// File: rtl/exe_stage_mc.sv
// exe_stage_mc: execute stage with single-cycle ALU path, iterative MUL/MLA and EX/MEM register.
module exe_stage_mc #(
    parameter int WORD_WIDTH            = exe_stage_mc_pkg::WORD_WIDTH,
    parameter int REG_FILE_DEPTH        = exe_stage_mc_pkg::REG_FILE_DEPTH,
    parameter int SIGNED_IMM_WIDTH      = exe_stage_mc_pkg::SIGNED_IMM_WIDTH,
    parameter int SHIFTER_OPERAND_WIDTH = exe_stage_mc_pkg::SHIFTER_OPERAND_WIDTH,
    parameter int BITS_PER_CYCLE        = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             freeze,
    input  logic                             flush,
    input  logic                             is_mul,
    input  logic                             is_mla,
    input  logic                             mem_read_in,
    input  logic                             mem_write_in,
    input  logic                             imm,
    input  logic                             WB_en_in,
    input  logic                             S_in,
    input  logic [3:0]                       EX_command,
    input  logic [3:0]                       SR_in,
    input  logic [SIGNED_IMM_WIDTH-1:0]      signed_immediate,
    input  logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand,
    input  logic [REG_FILE_DEPTH-1:0]        dst_in,
    input  logic [WORD_WIDTH-1:0]            pc_in,
    input  logic [WORD_WIDTH-1:0]            val_Rn_in,
    input  logic [WORD_WIDTH-1:0]            val_Rm_in,
    input  logic [WORD_WIDTH-1:0]            val_Ra_in,
    output logic                             out_valid,
    output logic                             mem_read_out,
    output logic                             mem_write_out,
    output logic                             WB_en_out,
    output logic [3:0]                       SR_out,
    output logic [REG_FILE_DEPTH-1:0]        dst_out,
    output logic [WORD_WIDTH-1:0]            ALU_res,
    output logic [WORD_WIDTH-1:0]            val_Rm_out,
    output logic [WORD_WIDTH-1:0]            branch_address
);
    import exe_stage_mc_pkg::*;

    localparam int M = WORD_WIDTH - 1;

    state_t                    state, state_next;
    logic [WORD_WIDTH-1:0]     imm8, imm_rot, rm_asr, rm_shift, val2, b_op, alu_out, mul_res;
    logic [WORD_WIDTH:0]       sum;
    logic [4:0]                rot, sh;
    logic [3:0]                alu_flags, mul_flags, sr_q;
    logic [REG_FILE_DEPTH-1:0] dst_q;
    logic                      sub, arith, cin, ovf, go, start, step, alu_fire, mul_iter_done, mul_done;
    logic                      wb_q, s_q;

    assign branch_address = pc_in + {{(WORD_WIDTH-SIGNED_IMM_WIDTH){signed_immediate[SIGNED_IMM_WIDTH-1]}}, signed_immediate};

    assign in_ready = state == IDLE;
    assign go       = !flush && !freeze;
    assign start    = go && in_ready && in_valid && is_mul;
    assign alu_fire = go && in_ready && in_valid && !is_mul;
    assign step     = go && state == MUL_BUSY;
    assign mul_done = step && mul_iter_done;

    // Val2: memory offset, rotated 8-bit immediate, or shifted Rm
    assign rm_asr = $signed(val_Rm_in) >>> sh;
    always_comb begin
        imm8     = WORD_WIDTH'(shifter_operand[7:0]);
        rot      = {shifter_operand[11:8], 1'b0};
        sh       = shifter_operand[11:7];
        imm_rot  = (imm8 >> rot) | (imm8 << (WORD_WIDTH - int'(rot)));
        rm_shift = shifter_operand[6:5] == 2'd0 ? val_Rm_in << sh :
                   shifter_operand[6:5] == 2'd1 ? val_Rm_in >> sh :
                   shifter_operand[6:5] == 2'd2 ? rm_asr :
                   (val_Rm_in >> sh) | (val_Rm_in << (WORD_WIDTH - int'(sh)));
        val2     = mem_read_in || mem_write_in ? WORD_WIDTH'(shifter_operand) : imm ? imm_rot : rm_shift;
    end

    // subtraction is a + ~b + carry-in, so one adder serves all four arithmetic ops
    always_comb begin
        sub       = EX_command == EXE_SUB || EX_command == EXE_SBC;
        arith     = sub || EX_command == EXE_ADD || EX_command == EXE_ADC;
        cin       = EX_command == EXE_SUB ? 1'b1 : (EX_command == EXE_ADC || EX_command == EXE_SBC) ? SR_in[1] : 1'b0;
        b_op      = sub ? ~val2 : val2;
        sum       = {1'b0, val_Rn_in} + {1'b0, b_op} + (WORD_WIDTH+1)'(cin);
        alu_out   = arith ? sum[M:0] :
                    EX_command == EXE_MOV ? val2 :
                    EX_command == EXE_MVN ? ~val2 :
                    EX_command == EXE_AND ? val_Rn_in & val2 :
                    EX_command == EXE_ORR ? val_Rn_in | val2 :
                    EX_command == EXE_EOR ? val_Rn_in ^ val2 : '0;
        ovf       = (val_Rn_in[M] == b_op[M]) && (sum[M] != val_Rn_in[M]);
        alu_flags = {alu_out[M], alu_out == '0, arith ? sum[WORD_WIDTH] : SR_in[1], arith ? ovf : SR_in[0]};
        mul_flags = {mul_res[M], mul_res == '0, sr_q[1:0]};
    end

    mul_iter #(.WIDTH(WORD_WIDTH), .BITS(BITS_PER_CYCLE)) u_mul (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .step         (step),
        .abort        (flush),
        .multiplicand (val_Rn_in),
        .multiplier   (val_Rm_in),
        .addend       (is_mla ? val_Ra_in : '0),
        .result       (mul_res),
        .done         (mul_iter_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) {dst_q, wb_q, s_q, sr_q} <= '0;
        else if (start) {dst_q, wb_q, s_q, sr_q} <= {dst_in, WB_en_in, S_in, SR_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush) state_next = IDLE;
        else if (start) state_next = MUL_BUSY;
        else if (mul_done) state_next = IDLE;
    end

    // bubbles clear only the control bits; data fields keep their last value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            mem_read_out  <= 1'b0;
            mem_write_out <= 1'b0;
            WB_en_out     <= 1'b0;
            SR_out        <= '0;
            dst_out       <= '0;
            ALU_res       <= '0;
            val_Rm_out    <= '0;
        end else if (flush || (!freeze && !alu_fire && !mul_done)) begin
            out_valid     <= 1'b0;
            mem_read_out  <= 1'b0;
            mem_write_out <= 1'b0;
            WB_en_out     <= 1'b0;
        end else if (alu_fire) begin
            out_valid     <= 1'b1;
            mem_read_out  <= mem_read_in;
            mem_write_out <= mem_write_in;
            WB_en_out     <= WB_en_in;
            SR_out        <= S_in ? alu_flags : SR_in;
            dst_out       <= dst_in;
            ALU_res       <= alu_out;
            val_Rm_out    <= val_Rm_in;
        end else if (mul_done) begin
            out_valid     <= 1'b1;
            mem_read_out  <= 1'b0;
            mem_write_out <= 1'b0;
            WB_en_out     <= wb_q;
            SR_out        <= s_q ? mul_flags : sr_q;
            dst_out       <= dst_q;
            ALU_res       <= mul_res;
        end
    end
endmodule
